axi_read_arbiter: RTL

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

---
 rtl/axi_read_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter with a single outstanding read.
// Grants the AR channel in IDLE, forwards it in ADDR and routes R beats back in DATA.
module axi_read_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ARID_M0,
    input  logic [31:0] ARADDR_M0,
    input  logic [3:0]  ARLEN_M0,
    input  logic [2:0]  ARSIZE_M0,
    input  logic [1:0]  ARBURST_M0,
    input  logic        ARVALID_M0,
    output logic        ARREADY_M0,
    input  logic [3:0]  ARID_M1,
    input  logic [31:0] ARADDR_M1,
    input  logic [3:0]  ARLEN_M1,
    input  logic [2:0]  ARSIZE_M1,
    input  logic [1:0]  ARBURST_M1,
    input  logic        ARVALID_M1,
    output logic        ARREADY_M1,
    output logic [3:0]  RID_M0,
    output logic [31:0] RDATA_M0,
    output logic [1:0]  RRESP_M0,
    output logic        RLAST_M0,
    output logic        RVALID_M0,
    input  logic        RREADY_M0,
    output logic [3:0]  RID_M1,
    output logic [31:0] RDATA_M1,
    output logic [1:0]  RRESP_M1,
    output logic        RLAST_M1,
    output logic        RVALID_M1,
    input  logic        RREADY_M1,
    output logic [7:0]  ARID_S,
    output logic [31:0] ARADDR_S,
    output logic [3:0]  ARLEN_S,
    output logic [2:0]  ARSIZE_S,
    output logic [1:0]  ARBURST_S,
    output logic        ARVALID_S,
    input  logic        ARREADY_S,
    input  logic [7:0]  RID_S,
    input  logic [31:0] RDATA_S,
    input  logic [1:0]  RRESP_S,
    input  logic        RLAST_S,
    input  logic        RVALID_S,
    output logic        RREADY_S,
    output logic [1:0]  dbg_state
);
    // A transfer happens on a rising edge where VALID and READY are both high;
    // VALID never depends on READY, and a master holds its request until accepted.
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        grant_q, last_grant_q, grant_sel, any_req, ar_take, r_last_hs;
    logic [7:0]  arid_q;
    logic [31:0] araddr_q;
    logic [3:0]  arlen_q;
    logic [2:0]  arsize_q;
    logic [1:0]  arburst_q;
    logic        unused_rid;

    // Grant encoding: 0 selects M0, 1 selects M1.
    always_comb begin
        any_req = ARVALID_M0 | ARVALID_M1;
        if (ARVALID_M0 && ARVALID_M1) begin
            grant_sel = RR_EN ? ~last_grant_q : 1'b0;
        end else begin
            grant_sel = ARVALID_M1;
        end
    end

    assign ar_take   = (state == IDLE) && any_req;
    assign r_last_hs = RVALID_S && RLAST_S && (grant_q ? RREADY_M1 : RREADY_M0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
        end else begin
            state <= state_nxt;
            if (ar_take) begin
                grant_q      <= grant_sel;
                last_grant_q <= grant_sel;
                arid_q       <= grant_sel ? {4'h1, ARID_M1} : {4'h0, ARID_M0};
                araddr_q     <= grant_sel ? ARADDR_M1 : ARADDR_M0;
                arlen_q      <= grant_sel ? ARLEN_M1 : ARLEN_M0;
                arsize_q     <= grant_sel ? ARSIZE_M1 : ARSIZE_M0;
                arburst_q    <= grant_sel ? ARBURST_M1 : ARBURST_M0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ARREADY_M0  = 1'b0;
        ARREADY_M1  = 1'b0;
        ARVALID_S   = 1'b0;
        RREADY_S    = 1'b0;
        RVALID_M0   = 1'b0;
        RID_M0      = '0;
        RDATA_M0    = '0;
        RRESP_M0    = '0;
        RLAST_M0    = 1'b0;
        RVALID_M1   = 1'b0;
        RID_M1      = '0;
        RDATA_M1    = '0;
        RRESP_M1    = '0;
        RLAST_M1    = 1'b0;
        case (state)
            IDLE: begin
                // Reset is asynchronous, so the combinational grant must be masked too.
                if (any_req && !rst) begin
                    ARREADY_M0 = ~grant_sel;
                    ARREADY_M1 = grant_sel;
                    state_nxt  = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S = 1'b1;
                if (ARREADY_S) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (grant_q) begin
                    RVALID_M1 = RVALID_S;
                    RREADY_S  = RREADY_M1;
                    RID_M1    = RID_S[3:0];
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                end else begin
                    RVALID_M0 = RVALID_S;
                    RREADY_S  = RREADY_M0;
                    RID_M0    = RID_S[3:0];
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                end
                if (r_last_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Routing uses the latched grant only; the upper RID bits carry no meaning here.
    assign unused_rid = ^RID_S[7:4];

    assign ARID_S    = arid_q;
    assign ARADDR_S  = araddr_q;
    assign ARLEN_S   = arlen_q;
    assign ARSIZE_S  = arsize_q;
    assign ARBURST_S = arburst_q;
    assign dbg_state = state;
endmodule
